perf_event_counters: RTL and testbench
======================================

Name: perf_event_counters

Overview:
- Synthesizable, parametrised performance-monitor block that instantiates inside proc_hier next to the core.
- Counts cycles, retired instructions and NUM_CH generic event strobes, e.g. I/D cache request and I/D cache hit.
- Freezes all counts when the core halts, so software or a bench can read stable totals through a one-cycle request/acknowledge read port.

Parameters:
- NUM_CH, 4, number of generic event channels (1..16).
- CNT_W, 32, width of every counter and of rd_data (8..32).
- SEL_W, 5, width of rd_sel; must satisfy 2^SEL_W >= NUM_CH+2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  counting enable; counters hold while low.
- clear  in  1  synchronous clear of all counters and flags.
- retire  in  1  one instruction retired this cycle (core asserts on halt | regwrite | memwrite in WB).
- halt  in  1  halt reached writeback this cycle.
- event_vld  in  NUM_CH  per-channel event strobe, one count per high cycle.
- rd_req  in  1  read request, sampled each rising edge.
- rd_sel  in  SEL_W  counter index: 0 = cycles, 1 = instructions, 2..NUM_CH+1 = channel (rd_sel-2).
- rd_ack  out  1  one-cycle pulse, rd_data valid.
- rd_data  out  CNT_W  selected counter value.
- rd_err  out  1  with rd_ack: rd_sel out of range.
- frozen  out  1  state is FROZEN.
- ovf  out  NUM_CH+2  sticky overflow flag per counter, same index order as rd_sel.

Behaviour:
- **Reset (rst low, asynchronous):**
  - State goes to IDLE.
  - All counters, ovf, rd_data, rd_ack, rd_err and frozen go to 0.
- **State machine:**
  - IDLE: no counting. Goes to RUN on the first cycle with en=1; that cycle counts.
  - RUN, on each edge with en=1:
    - Cycle counter +1.
    - Instruction counter +1 if retire.
    - Channel k +1 if event_vld[k].
    - Halt with en=1: that cycle's increments still apply, then state goes to FROZEN.
  - RUN with en=0: all counters hold; halt is ignored.
  - FROZEN: no counter changes; frozen=1. Exits only via clear (to IDLE) or reset.
  - Halt while in IDLE is ignored.
- **Priority:** clear beats halt, which beats increments.
  - clear in any state zeroes all counters and ovf, sets state to IDLE, and suppresses that cycle's increments.
- **Width and overflow:**
  - Counter at 2^CNT_W-1 that receives an increment wraps to 0 and sets its ovf bit.
  - ovf stays set until clear or reset.
- **Read port:**
  - rd_req sampled at edge N.
  - At edge N+1: rd_ack=1 for exactly one cycle and rd_data holds the counter value as of edge N, i.e. before edge-N increments.
  - rd_data holds its value until the next acknowledged read.
  - Back-to-back rd_req on consecutive cycles are each acknowledged; throughput is 1 read/cycle.
  - Out-of-range rd_sel returns rd_data=0 with rd_err=1 alongside rd_ack.
  - Reads are legal in every state and never alter counters.
  - Read and clear on the same edge: rd_data returns the pre-clear value.
- **Reset mid-read:** a pending rd_ack is cancelled and no acknowledge is issued.

Optional Feature:
- Macro: PERF_SAT_EN.
- Defined: counters saturate. A counter at 2^CNT_W-1 stays there on further increments and sets its ovf bit; no wrap.
- Undefined: wrap-around behaviour as described above.
- All other behaviour is identical with or without the macro.

Test Plan:
- **Basic counting:** reset, en=1 for 10 cycles; retire high on 6 of them; event_vld[0] high 3 cycles, [1] high 2 cycles.
  - Reads of sel 0/1/2/3 return 10/6/3/2; rd_ack one cycle after each rd_req; rd_err=0.
- **Halt freeze:** RUN, halt with retire on cycle 20, then 5 more cycles with retire and events.
  - frozen=1; sel0=20, instructions include the halt cycle; no change after freeze.
- **Clear priority:** clear and halt asserted on the same edge.
  - State IDLE, frozen=0, all reads 0, ovf=0.
  - After en=1 for 3 cycles, sel0=3.
- **Wrap, CNT_W=8:** 257 enabled cycles.
  - Without PERF_SAT_EN: sel0=1, ovf[0]=1.
  - With PERF_SAT_EN: sel0=255, ovf[0]=1.
- **Read edge cases, NUM_CH=4:**
  - rd_sel=7 gives rd_data=0, rd_err=1.
  - rd_req on 3 consecutive cycles gives 3 consecutive rd_ack pulses.
  - rst asserted the cycle after rd_req gives no rd_ack.
- **Enable gating:** en toggled 1,0,1,0,1 with retire always high.
  - sel0=3, sel1=3; halt during an en=0 cycle keeps the state RUN.

Source files
------------

// File: rtl/perf_event_counters.sv
// Performance monitor: cycle, retired-instruction and NUM_CH event counters that freeze on core halt.
// Define PERF_SAT_EN to make counters saturate at all-ones instead of wrapping.
module perf_event_counters #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned SEL_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear,
    input  logic              retire,
    input  logic              halt,
    input  logic [NUM_CH-1:0] event_vld,
    input  logic              rd_req,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic              rd_ack,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_err,
    output logic              frozen,
    output logic [NUM_CH+1:0] ovf
);

    localparam int unsigned NCNT = NUM_CH + 2;

    typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt [NCNT];
    logic [NCNT-1:0]  inc;
    logic             counting;
    logic [CNT_W-1:0] sel_val;
    logic             sel_ok;
    logic             pend;
    logic [CNT_W-1:0] pend_data;
    logic             pend_err;

    always_comb begin
        inc      = {event_vld, retire, 1'b1};
        counting = en && (state != FROZEN);
        sel_val  = '0;
        sel_ok   = 1'b0;
        for (int unsigned i = 0; i < NCNT; i++) begin
            if (32'(rd_sel) == i) begin
                sel_val = cnt[i];
                sel_ok  = 1'b1;
            end
        end
    end

    // Reads are captured at the request edge (pre-increment, pre-clear) and presented one edge later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            for (int unsigned i = 0; i < NCNT; i++) cnt[i] <= '0;
            ovf       <= '0;
            frozen    <= 1'b0;
            pend      <= 1'b0;
            pend_data <= '0;
            pend_err  <= 1'b0;
            rd_ack    <= 1'b0;
            rd_data   <= '0;
            rd_err    <= 1'b0;
        end else begin
            pend      <= rd_req;
            pend_data <= sel_ok ? sel_val : '0;
            pend_err  <= !sel_ok;
            rd_ack    <= pend;
            rd_err    <= pend && pend_err;
            if (pend) rd_data <= pend_data;

            if (clear) begin
                state  <= IDLE;
                frozen <= 1'b0;
                ovf    <= '0;
                for (int unsigned i = 0; i < NCNT; i++) cnt[i] <= '0;
            end else if (counting) begin
                for (int unsigned i = 0; i < NCNT; i++) begin
                    if (inc[i]) begin
                        if (cnt[i] == '1) begin
                            ovf[i] <= 1'b1;
`ifdef PERF_SAT_EN
                            cnt[i] <= cnt[i];
`else
                            cnt[i] <= '0;
`endif
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                end
                // Halt only freezes from RUN; in IDLE the first enabled cycle always enters RUN.
                if (state == RUN && halt) begin
                    state  <= FROZEN;
                    frozen <= 1'b1;
                end else begin
                    state <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_perf_event_counters.sv
// Directed bench for perf_event_counters (NUM_CH=4, CNT_W=8); read results checked through a scoreboard queue.
module tb_perf_event_counters;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SEL_W  = 5;

`ifdef PERF_SAT_EN
    localparam logic [7:0] WRAP_EXP = 8'd255;
`else
    localparam logic [7:0] WRAP_EXP = 8'd1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              clear = 1'b0;
    logic              retire = 1'b0;
    logic              halt = 1'b0;
    logic [NUM_CH-1:0] event_vld = '0;
    logic              rd_req = 1'b0;
    logic [SEL_W-1:0]  rd_sel = '0;
    logic              rd_ack;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_err;
    logic              frozen;
    logic [NUM_CH+1:0] ovf;

    typedef struct {
        int         due;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t q[$];
    exp_t e_m;
    int   cyc = 0;
    int   npass = 0;
    int   ntot = 0;

    perf_event_counters #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .SEL_W (SEL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clear    (clear),
        .retire   (retire),
        .halt     (halt),
        .event_vld(event_vld),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .rd_ack   (rd_ack),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .frozen   (frozen),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle request; the acknowledge is due two bench cycles after the drive point.
    task automatic rd(input logic [SEL_W-1:0] sel, input logic [7:0] d, input logic err);
        exp_t x;
        x.due  = cyc + 2;
        x.data = d;
        x.err  = err;
        q.push_back(x);
        rd_req = 1'b1;
        rd_sel = sel;
        tick(1);
        rd_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            e_m = q.pop_front();
            chk("rd_ack", 64'(rd_ack), 64'd1);
            chk("rd_data", 64'(rd_data), 64'(e_m.data));
            chk("rd_err", 64'(rd_err), 64'(e_m.err));
        end else begin
            chk("rd_ack_idle", 64'(rd_ack), 64'd0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(2);
        chk("rst_frozen", 64'(frozen), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_rd_err", 64'(rd_err), 64'd0);
        rst = 1'b1;
        tick(1);
        rd(0, 8'd0, 1'b0);
        tick(2);

        // Basic counting
        for (int i = 0; i < 10; i++) begin
            en        = 1'b1;
            retire    = (i < 6);
            event_vld = {2'b00, (i < 2), (i < 3)};
            tick(1);
        end
        en = 1'b0; retire = 1'b0; event_vld = '0;
        rd(0, 8'd10, 1'b0);
        rd(1, 8'd6, 1'b0);
        rd(2, 8'd3, 1'b0);
        rd(3, 8'd2, 1'b0);
        rd(5, 8'd0, 1'b0);
        rd(6, 8'd0, 1'b1);
        rd(7, 8'd0, 1'b1);
        tick(2);
        chk("basic_frozen", 64'(frozen), 64'd0);
        chk("basic_ovf", 64'(ovf), 64'd0);

        // Halt freeze
        clear = 1'b1; tick(1); clear = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            en = 1'b1; retire = 1'b1; halt = (i == 20); event_vld = 4'b0100;
            tick(1);
        end
        halt = 1'b0;
        chk("halt_frozen", 64'(frozen), 64'd1);
        event_vld = 4'hF;
        tick(5);
        en = 1'b0; retire = 1'b0; event_vld = '0;
        chk("halt_frozen_hold", 64'(frozen), 64'd1);
        rd(0, 8'd20, 1'b0);
        rd(1, 8'd20, 1'b0);
        rd(2, 8'd0, 1'b0);
        rd(4, 8'd20, 1'b0);
        tick(2);

        // Clear beats halt; read on the clear edge returns the pre-clear value
        clear = 1'b1; halt = 1'b1; en = 1'b1; retire = 1'b1; event_vld = 4'hF;
        rd(0, 8'd20, 1'b0);
        clear = 1'b0; halt = 1'b0; en = 1'b0; retire = 1'b0; event_vld = '0;
        chk("clr_frozen", 64'(frozen), 64'd0);
        chk("clr_ovf", 64'(ovf), 64'd0);
        rd(0, 8'd0, 1'b0);
        rd(1, 8'd0, 1'b0);
        rd(2, 8'd0, 1'b0);
        tick(2);
        // Halt on the IDLE->RUN cycle is ignored
        en = 1'b1; halt = 1'b1; tick(1);
        halt = 1'b0; tick(2);
        en = 1'b0;
        chk("clr_idle_halt", 64'(frozen), 64'd0);
        rd(0, 8'd3, 1'b0);
        rd(1, 8'd0, 1'b0);
        tick(2);

        // Enable gating
        clear = 1'b1; tick(1); clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en = (i % 2 == 0); retire = 1'b1; halt = (i % 2 == 1);
            tick(1);
        end
        en = 1'b0; halt = 1'b0; retire = 1'b0;
        chk("gate_frozen", 64'(frozen), 64'd0);
        rd(0, 8'd3, 1'b0);
        rd(1, 8'd3, 1'b0);
        tick(2);
        en = 1'b1; halt = 1'b1; tick(1);
        en = 1'b0; halt = 1'b0;
        chk("gate_run_halt", 64'(frozen), 64'd1);
        rd(0, 8'd4, 1'b0);
        rd(1, 8'd3, 1'b0);
        tick(2);

        // Wrap / saturate at CNT_W=8
        clear = 1'b1; tick(1); clear = 1'b0;
        en = 1'b1; tick(257); en = 1'b0;
        rd(0, WRAP_EXP, 1'b0);
        rd(1, 8'd0, 1'b0);
        tick(2);
        chk("wrap_ovf", 64'(ovf), 64'h01);
        clear = 1'b1; tick(1); clear = 1'b0;
        chk("wrap_ovf_cleared", 64'(ovf), 64'd0);
        rd(0, 8'd0, 1'b0);
        tick(2);

        // Reset while a read is pending: no acknowledge
        clear = 1'b1; tick(1); clear = 1'b0;
        en = 1'b1; tick(5); en = 1'b0;
        rd_req = 1'b1; rd_sel = 0;
        tick(1);
        rd_req = 1'b0;
        rst = 1'b0;
        tick(3);
        chk("rstmid_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b1;
        tick(1);
        rd(0, 8'd0, 1'b0);
        rd(7, 8'd0, 1'b1);

        for (int i = 0; i < 10 && q.size() > 0; i++) tick(1);
        tick(1);
        chk("drain", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
